mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 23 ++
 rtl/mult_div_unit_if.sv | 37 +++
 rtl/muldiv_step.sv | 31 +++
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 tb/tb_mult_div_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared function codes and multiply/divide FSM state type
package mult_div_unit_pkg;

    typedef enum logic [5:0] {
        FUNCT_MULT  = 6'h18,
        FUNCT_MULTU = 6'h19,
        FUNCT_DIV   = 6'h1a,
        FUNCT_DIVU  = 6'h1b
    } funct_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Only the four multiply/divide codes may start the unit.
    function automatic logic funct_is_muldiv(input funct_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle of the multiply/divide unit (div_zero under MULDIV_DIV_ZERO_FLAG_EN)
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    funct_t           fncode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIV_ZERO_FLAG_EN
    logic             div_zero;
`endif

    modport master (
        output start, fncode, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
`ifdef MULDIV_DIV_ZERO_FLAG_EN
        , input div_zero
`endif
    );

    modport slave (
        input  start, fncode, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
`ifdef MULDIV_DIV_ZERO_FLAG_EN
        , output div_zero
`endif
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] upper_nxt,
    output logic [WIDTH-1:0] lower_nxt
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    // Multiply: add multiplicand on low multiplier bit, shift right.
    // Divide: shift remainder left, keep the trial subtraction if it fits.
    always_comb begin
        sum       = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
        shifted   = {upper, lower[WIDTH-1]};
        borrow    = shifted < {1'b0, operand};
        diff      = shifted[WIDTH-1:0] - operand;
        upper_nxt = sum[WIDTH:1];
        lower_nxt = {sum[0], lower[WIDTH-1:1]};
        if (is_div) begin
            upper_nxt = borrow ? shifted[WIDTH-1:0] : diff;
            lower_nxt = {lower[WIDTH-2:0], ~borrow};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit (optional div_zero flag: MULDIV_DIV_ZERO_FLAG_EN)
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    funct_t           fn_q, fn_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] upper_q, upper_d, lower_q, lower_d, operand_q, operand_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             accept, signed_op, div_op, b_zero, neg_res;
    logic [WIDTH-1:0] mag_a, mag_b, step_upper, step_lower, quo, rem;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? ('0 - x) : x;
    endfunction

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (div_op),
        .upper     (upper_q),
        .lower     (lower_q),
        .operand   (operand_q),
        .upper_nxt (step_upper),
        .lower_nxt (step_lower)
    );

    // Next state: accept/latch in IDLE, magnitude load then WIDTH steps in RUN, sign fix-up in FIX.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fn_d       = fn_q;
        a_d        = a_q;
        b_d        = b_q;
        upper_d    = upper_q;
        lower_d    = lower_q;
        operand_d  = operand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        accept    = (state_q == IDLE) && bus.start && funct_is_muldiv(bus.fncode);
        signed_op = (fn_q == FUNCT_MULT) || (fn_q == FUNCT_DIV);
        div_op    = (fn_q == FUNCT_DIV) || (fn_q == FUNCT_DIVU);
        b_zero    = (b_q == '0);
        mag_a     = magnitude(a_q, signed_op);
        mag_b     = magnitude(b_q, signed_op);
        neg_res   = signed_op && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        prod      = neg_res ? ('0 - {upper_q, lower_q}) : {upper_q, lower_q};
        quo       = neg_res ? ('0 - lower_q) : lower_q;
        rem       = (signed_op && a_q[WIDTH-1]) ? ('0 - upper_q) : upper_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    fn_d    = bus.fncode;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    upper_d   = '0;
                    lower_d   = div_op ? mag_a : mag_b;
                    operand_d = div_op ? mag_b : mag_a;
                    cnt_d     = cnt_q + 1'b1;
                end else begin
                    upper_d = step_upper;
                    lower_d = step_lower;
                    if (cnt_q == CW'(WIDTH)) state_d = FIX;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
            end
            FIX: begin
                if (!div_op) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_zero) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d     = 1'b1;
                div_zero_d = div_op && b_zero;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fn_q       <= FUNCT_MULT;
            a_q        <= '0;
            b_q        <= '0;
            upper_q    <= '0;
            lower_q    <= '0;
            operand_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fn_q       <= fn_d;
            a_q        <= a_d;
            b_q        <= b_d;
            upper_q    <= upper_d;
            lower_q    <= lower_d;
            operand_q  <= operand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MULDIV_DIV_ZERO_FLAG_EN
    assign bus.div_zero = div_zero_q;
`else
    logic unused_div_zero;
    assign unused_div_zero = div_zero_q;
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input funct_t fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input logic ghost);
        int lat = 0;
        logic early = 1'b0;
        int extra = 0;
        bus.start  = 1'b1;
        bus.fncode = fn;
        bus.a      = a;
        bus.b      = b;
        tick();
        bus.start = 1'b0;
        bus.a     = 32'h5a5a_a5a5;
        bus.b     = 32'h0f0f_f0f0;
        check({tag, "_busy_accept"}, bus.busy, 1'b1);
        for (int n = 1; n <= 100; n++) begin
            if (ghost && n == 4) begin
                bus.start  = 1'b1;
                bus.fncode = FUNCT_MULTU;
                bus.a      = 32'd6;
                bus.b      = 32'd7;
            end
            if (ghost && n == 5) bus.start = 1'b0;
            tick();
            if (bus.done) begin
                lat = n;
                break;
            end
            if (!bus.busy) early = 1'b1;
        end
        check({tag, "_latency"}, lat, 34);
        check({tag, "_busy_early"}, early, 1'b0);
        check({tag, "_busy_at_done"}, bus.busy, 1'b0);
        check({tag, "_hi"}, bus.hi, ehi);
        check({tag, "_lo"}, bus.lo, elo);
`ifdef MULDIV_DIV_ZERO_FLAG_EN
        check({tag, "_div_zero"}, bus.div_zero, edz);
`endif
        tick();
        check({tag, "_done_one_cycle"}, bus.done, 1'b0);
        if (ghost) begin
            for (int n = 0; n < 40; n++) begin
                if (bus.done) extra++;
                tick();
            end
            check({tag, "_extra_done"}, extra, 0);
            check({tag, "_lo_kept"}, bus.lo, elo);
        end
    endtask

    initial begin
        int dones;
        bus.start  = 1'b0;
        bus.fncode = FUNCT_MULTU;
        bus.a      = '0;
        bus.b      = '0;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.wdata  = '0;
        repeat (3) tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);

        reset_n = 1'b1;
        run_op("multu_max", FUNCT_MULTU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mult_neg", FUNCT_MULT, 32'hffff_fffd, 32'd7, 32'hffff_ffff, 32'hffff_ffeb, 1'b0, 1'b0);
        run_op("div_neg", FUNCT_DIV, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 1'b0, 1'b0);
        run_op("divu_zero", FUNCT_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hffff_ffff, 1'b1, 1'b0);
        run_op("div_zero_s", FUNCT_DIV, 32'hffff_fffb, 32'd0, 32'hffff_fffb, 32'hffff_ffff, 1'b1, 1'b0);
        run_op("div_min", FUNCT_DIV, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        run_op("divu_ghost", FUNCT_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, 1'b1);

        bus.start  = 1'b1;
        bus.fncode = funct_t'(6'h00);
        tick();
        bus.start = 1'b0;
        check("bad_fn_busy", bus.busy, 1'b0);

        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234;
        tick();
        bus.hi_we = 1'b0;
        check("mthi_hi", bus.hi, 32'h1234);
        check("mthi_lo", bus.lo, 32'd3);

        bus.start  = 1'b1;
        bus.fncode = FUNCT_MULTU;
        bus.a      = 32'd6;
        bus.b      = 32'd7;
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hdead;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("busy_we_hi", bus.hi, 32'h1234);
        check("busy_we_lo", bus.lo, 32'd3);
        for (int n = 0; n < 60 && !bus.done; n++) tick();
        check("mul67_done", bus.done, 1'b1);
        check("mul67_lo", bus.lo, 32'd42);
        check("mul67_hi", bus.hi, 32'd0);
        tick();

        bus.start  = 1'b1;
        bus.fncode = FUNCT_DIVU;
        bus.a      = 32'd1000;
        bus.b      = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.hi_we = 1'b1;
        bus.wdata = 32'h77;
        tick();
        bus.hi_we = 1'b0;
        check("pre_rst_busy", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_hi", bus.hi, 32'h0);
        check("mid_rst_lo", bus.lo, 32'h0);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.done) dones++;
            tick();
        end
        check("mid_rst_no_done", dones, 0);
        reset_n = 1'b1;
        run_op("post_rst", FUNCT_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
